// File: rtl/dffnrsnq_pipe_pkg.sv
// rtl/dffnrsnq_pipe_pkg.sv - shared op encoding, priority decode and fill-width helper
package dffnrsnq_pipe_pkg;

    typedef enum logic [2:0] {
        OP_RESET = 3'd0,
        OP_SET   = 3'd1,
        OP_SCAN  = 3'd2,
        OP_SHIFT = 3'd3,
        OP_HOLD  = 3'd4
    } op_e;

    // Width needed to count 0..depth inclusive
    function automatic int fill_width(input int depth);
        return $clog2(depth + 1);
    endfunction

    // Reset beats set, set beats scan, scan beats shift
    function automatic op_e op_decode(input logic rst, input logic setn,
                                      input logic se, input logic en);
        if (rst)
            return OP_RESET;
        else if (!setn)
            return OP_SET;
        else if (se)
            return OP_SCAN;
        else if (en)
            return OP_SHIFT;
        else
            return OP_HOLD;
    endfunction

endpackage

// File: rtl/dffnrsnq_pipe_stage.sv
// rtl/dffnrsnq_pipe_stage.sv - one falling-edge data register with its valid flag
module dffnrsnq_pipe_stage
    import dffnrsnq_pipe_pkg::*;
#(
    parameter int              WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0,
    parameter logic [WIDTH-1:0] SET_VAL   = '1
) (
    input  logic             clk,
    input  op_e              op,
    input  logic [WIDTH-1:0] par_d,
    input  logic             par_vld,
    input  logic             ser_in,
    output logic [WIDTH-1:0] q,
    output logic             vld
);

    // Serial shift moves every bit one place up; the concat handles WIDTH=1
    logic [WIDTH:0] scan_cat;
    assign scan_cat = {q, ser_in};

    // Register update on the falling edge according to the decoded op
    always_ff @(negedge clk) begin
        case (op)
            OP_RESET: begin
                q   <= RESET_VAL;
                vld <= 1'b0;
            end
            OP_SET: begin
                q   <= SET_VAL;
                vld <= 1'b1;
            end
            OP_SCAN: begin
                q   <= scan_cat[WIDTH-1:0];
            end
            OP_SHIFT: begin
                q   <= par_d;
                vld <= par_vld;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/dffnrsnq_pipe.sv
// rtl/dffnrsnq_pipe.sv - falling-edge set/reset register pipeline with occupancy count (optional scan: GF180_DFFNRSNQ_PIPE_SCAN_EN)
module dffnrsnq_pipe
    import dffnrsnq_pipe_pkg::*;
#(
    parameter int               WIDTH     = 8,
    parameter int               DEPTH     = 2,
    parameter logic [WIDTH-1:0] RESET_VAL = '0,
    parameter logic [WIDTH-1:0] SET_VAL   = '1
) (
    input  logic                          CLKN,
    input  logic                          RST,
    input  logic                          SETN,
    input  logic                          EN,
    input  logic [WIDTH-1:0]              D,
    input  logic                          VLD_I,
`ifdef GF180_DFFNRSNQ_PIPE_SCAN_EN
    input  logic                          SE,
    input  logic                          SI,
    output logic                          SO,
`endif
    output logic [WIDTH-1:0]              Q,
    output logic                          VLD_O,
    output logic [fill_width(DEPTH)-1:0]  FILL,
    output logic                          FULL
);

    localparam int FW = fill_width(DEPTH);

    logic             se;
    logic             si;
    op_e              op;
    logic [WIDTH-1:0] stage_q   [DEPTH];
    logic             stage_vld [DEPTH];
    logic [FW-1:0]    fill_q;

`ifdef GF180_DFFNRSNQ_PIPE_SCAN_EN
    assign se = SE;
    assign si = SI;
    assign SO = stage_q[DEPTH-1][WIDTH-1];
`else
    assign se = 1'b0;
    assign si = 1'b0;
`endif

    assign op = op_decode(RST, SETN, se, EN);

    for (genvar k = 0; k < DEPTH; k++) begin : g_stage
        logic [WIDTH-1:0] par_d;
        logic             par_vld;
        logic             ser_in;
        if (k == 0) begin : g_head
            assign par_d   = D;
            assign par_vld = VLD_I;
            assign ser_in  = si;
        end else begin : g_body
            assign par_d   = stage_q[k-1];
            assign par_vld = stage_vld[k-1];
            assign ser_in  = stage_q[k-1][WIDTH-1];
        end
        dffnrsnq_pipe_stage #(
            .WIDTH     (WIDTH),
            .RESET_VAL (RESET_VAL),
            .SET_VAL   (SET_VAL)
        ) u_stage (
            .clk     (CLKN),
            .op      (op),
            .par_d   (par_d),
            .par_vld (par_vld),
            .ser_in  (ser_in),
            .q       (stage_q[k]),
            .vld     (stage_vld[k])
        );
    end

    // Occupancy tracks valid flags entering and leaving; it cannot leave 0..DEPTH
    always_ff @(negedge CLKN) begin
        case (op)
            OP_RESET: fill_q <= '0;
            OP_SET:   fill_q <= FW'(DEPTH);
            OP_SHIFT: fill_q <= fill_q + FW'(VLD_I) - FW'(stage_vld[DEPTH-1]);
            default:  ;
        endcase
    end

    assign Q     = stage_q[DEPTH-1];
    assign VLD_O = stage_vld[DEPTH-1];
    assign FILL  = fill_q;
    assign FULL  = (fill_q == FW'(DEPTH));

endmodule

// File: tb/tb_dffnrsnq_pipe.sv
// tb/tb_dffnrsnq_pipe.sv - directed self-checking bench for dffnrsnq_pipe
module tb_dffnrsnq_pipe;

    logic       clkn = 1'b1;
    logic       rst, setn, en, vld_i;
    logic [7:0] d;
    logic [7:0] q;
    logic       vld_o, full;
    logic [1:0] fill;

    int checks = 0;
    int errors = 0;

    always #5 clkn = ~clkn;

`ifdef GF180_DFFNRSNQ_PIPE_SCAN_EN
    logic       so_main;
    logic       s_rst, s_setn, s_en, s_vld_i, s_se, s_si, s_so;
    logic [3:0] s_d, s_q;
    logic       s_vld_o, s_full;
    logic [1:0] s_fill;
`endif

    dffnrsnq_pipe #(.WIDTH(8), .DEPTH(3)) dut (
        .CLKN  (clkn),
        .RST   (rst),
        .SETN  (setn),
        .EN    (en),
        .D     (d),
        .VLD_I (vld_i),
`ifdef GF180_DFFNRSNQ_PIPE_SCAN_EN
        .SE    (1'b0),
        .SI    (1'b0),
        .SO    (so_main),
`endif
        .Q     (q),
        .VLD_O (vld_o),
        .FILL  (fill),
        .FULL  (full)
    );

`ifdef GF180_DFFNRSNQ_PIPE_SCAN_EN
    dffnrsnq_pipe #(.WIDTH(4), .DEPTH(2)) dut_scan (
        .CLKN  (clkn),
        .RST   (s_rst),
        .SETN  (s_setn),
        .EN    (s_en),
        .D     (s_d),
        .VLD_I (s_vld_i),
        .SE    (s_se),
        .SI    (s_si),
        .SO    (s_so),
        .Q     (s_q),
        .VLD_O (s_vld_o),
        .FILL  (s_fill),
        .FULL  (s_full)
    );
`endif

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clkn);
        #1;
    endtask

    task automatic push(input logic [7:0] dv, input logic v);
        d     = dv;
        vld_i = v;
        en    = 1'b1;
        step();
    endtask

    task automatic expect_out(input string tag, input logic [7:0] eq, input logic ev,
                              input logic [1:0] ef);
        check({tag, ".q"},    32'(q),     32'(eq));
        check({tag, ".vld"},  32'(vld_o), 32'(ev));
        check({tag, ".fill"}, 32'(fill),  32'(ef));
        check({tag, ".full"}, 32'(full),  32'(ef == 2'd3));
    endtask

    initial begin
        rst = 1'b1; setn = 1'b1; en = 1'b0; vld_i = 1'b0; d = 8'h00;
`ifdef GF180_DFFNRSNQ_PIPE_SCAN_EN
        s_rst = 1'b1; s_setn = 1'b1; s_en = 1'b0; s_vld_i = 1'b0;
        s_se = 1'b0; s_si = 1'b0; s_d = 4'h0;
`endif
        step();
        expect_out("reset", 8'h00, 1'b0, 2'd0);
        rst = 1'b0;

        // Fill
        push(8'hA1, 1'b1); expect_out("fill1", 8'h00, 1'b0, 2'd1);
        push(8'hB2, 1'b1); expect_out("fill2", 8'h00, 1'b0, 2'd2);
        push(8'hC3, 1'b1); expect_out("fill3", 8'hA1, 1'b1, 2'd3);
        // Drain
        push(8'h00, 1'b0); expect_out("drain1", 8'hB2, 1'b1, 2'd2);
        push(8'h00, 1'b0); expect_out("drain2", 8'hC3, 1'b1, 2'd1);
        push(8'h00, 1'b0); expect_out("drain3", 8'h00, 1'b0, 2'd0);

        // Set, then set together with reset
        setn = 1'b0; step();
        expect_out("set", 8'hFF, 1'b1, 2'd3);
        rst = 1'b1; step();
        expect_out("set_rst", 8'h00, 1'b0, 2'd0);
        rst = 1'b0; setn = 1'b1;

        // Stall mid-stream
        push(8'h11, 1'b1);
        push(8'h22, 1'b1); expect_out("pre_stall", 8'h00, 1'b0, 2'd2);
        en = 1'b0; d = 8'h99; vld_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            expect_out("stall", 8'h00, 1'b0, 2'd2);
        end
        push(8'h33, 1'b1); expect_out("resume1", 8'h11, 1'b1, 2'd3);
        push(8'h44, 1'b1); expect_out("resume2", 8'h22, 1'b1, 2'd3);
        push(8'h00, 1'b0); expect_out("resume3", 8'h33, 1'b1, 2'd2);

        // Reset discards in-flight 5A
        push(8'h5A, 1'b1); expect_out("pre_rst", 8'h44, 1'b1, 2'd2);
        rst = 1'b1; d = 8'h66; vld_i = 1'b1; en = 1'b1; step();
        expect_out("mid_rst", 8'h00, 1'b0, 2'd0);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            push(8'h00, 1'b0);
            expect_out("post_rst", 8'h00, 1'b0, 2'd0);
        end

`ifdef GF180_DFFNRSNQ_PIPE_SCAN_EN
        begin
            logic [7:0] si_pat;
            logic [7:0] so_exp;
            // Chain before scan is {stage1, stage0} = {4'h6, 4'h9} = 0110_1001
            si_pat = 8'b1011_0010;   // SI bits in order 1,0,1,1,0,0,1,0
            so_exp = 8'b1101_0011;   // SO after edges 1..8: 1,1,0,1,0,0,1,1
            s_rst = 1'b0; s_en = 1'b1; s_vld_i = 1'b1;
            s_d = 4'h6; step();
            s_d = 4'h9; step();
            check("scan.pre_fill", 32'(s_fill), 32'd2);
            check("scan.pre_so",   32'(s_so),   32'd0);
            s_se = 1'b1; s_d = 4'hF; s_vld_i = 1'b0;
            for (int i = 0; i < 8; i++) begin
                s_si = si_pat[7-i];
                step();
                check("scan.so",   32'(s_so),   32'(so_exp[7-i]));
                check("scan.fill", 32'(s_fill), 32'd2);
            end
            check("scan.q", 32'(s_q), 32'h0000000B);
            check("scan.vld", 32'(s_vld_o), 32'd1);
            s_se = 1'b0;
        end
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
